// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch
// and the data stage. Data has fixed priority; a starvation counter forces a
// fetch grant after STARVE_MAX data grants while fetch waits. One
// transaction is in flight at a time.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    // fetch side
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // data side
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_type,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory side
    output logic              m_req,
    output logic              m_we,
    output logic [2:0]        m_type,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
    localparam logic [2:0] TYPE_WORD = 3'b010;

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    state_t           state_q, state_d;
    logic             done_q;     // completion cycle: rvalid slot, no arbitration
    logic             flush_q;    // in-flight fetch has been squashed
    logic [CNT_W-1:0] starve_cnt;
    logic             done;
    logic             fetch_forced;

    assign done         = (state_q != IDLE) && m_ack;
    assign fetch_forced = if_req && (starve_cnt == CNT_MAX);

    // Next state and combinational grant; grants are masked while in reset
    // and in the completion cycle so grants are at least 3 cycles apart.
    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        d_gnt   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset && !done_q) begin
                    if (d_req && !fetch_forced) begin
                        d_gnt   = 1'b1;
                        state_d = BUSY_D;
                    end else if (if_req) begin
                        if_gnt  = 1'b1;
                        state_d = BUSY_IF;
                    end
                end
            end
            BUSY_IF: if (m_ack) state_d = IDLE;
            BUSY_D:  if (m_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus the completion-cycle marker.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done;
        end
    end

    // Memory request: capture the winner's fields, hold them until ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_req   <= 1'b0;
            m_we    <= 1'b0;
            m_type  <= 3'b000;
            m_addr  <= '0;
            m_wdata <= '0;
        end else if (d_gnt) begin
            m_req   <= 1'b1;
            m_we    <= d_we;
            m_type  <= d_type;
            m_addr  <= d_addr;
            m_wdata <= d_wdata;
        end else if (if_gnt) begin
            m_req   <= 1'b1;
            m_we    <= 1'b0;
            m_type  <= TYPE_WORD;
            m_addr  <= if_addr;
            m_wdata <= '0;
        end else if (done) begin
            m_req   <= 1'b0;
        end
    end

    // Flush latch: set during a fetch in flight or in its grant cycle,
    // cleared when that fetch completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_q <= 1'b0;
        end else if (done && state_q == BUSY_IF) begin
            flush_q <= 1'b0;
        end else if (if_flush && (state_q == BUSY_IF || if_gnt)) begin
            flush_q <= 1'b1;
        end
    end

    // Fetch completion: pulse rvalid and update rdata unless squashed, so
    // if_rdata keeps its last delivered word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            if (done && state_q == BUSY_IF && !(flush_q || if_flush)) begin
                if_rvalid <= 1'b1;
                if_rdata  <= m_rdata;
            end
        end
    end

    // Data completion: pulse for loads and stores; only loads touch d_rdata.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
        end else begin
            d_rvalid <= 1'b0;
            if (done && state_q == BUSY_D) begin
                d_rvalid <= 1'b1;
                if (!m_we) d_rdata <= m_rdata;
            end
        end
    end

    // Starvation counter: counts data grants that overtook a waiting fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (d_gnt && starve_cnt != CNT_MAX) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: table vectors, directed corner sequences and a
// randomized run, all checked against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req, if_flush, if_gnt, if_rvalid;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_gnt, d_rvalid;
    logic [2:0]    d_type;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          m_req, m_we, m_ack;
    logic [2:0]    m_type;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_type(d_type), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_type(m_type), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_chk = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Memory contents: written words, else a fixed hash of the address.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: one owner of memory at a time, a one-cycle rest after
    // each completion, starve = data grants since fetch last won or went idle.
    bit          busy, cool, t_if, flushed, exp_ifv, exp_dv;
    bit          last_wi, last_wd, first_m, auto_rq, rand_dly, stray;
    logic [31:0] t_addr, t_wdata, exp_ifd, exp_dd;
    logic        t_we;
    logic [2:0]  t_type;
    int          starve, wait_n, ack_dly;
    int          gnt_cyc, if_gnt_cyc, mreq_first, mreq_last, last_ifv_cyc, last_dv_cyc;
    int          n_ifv, n_dv;
    byte         gq[$];

    task automatic model_clear();
        busy = 0; cool = 0; starve = 0; exp_ifv = 0; exp_dv = 0;
        exp_ifd = '0; exp_dd = '0; wait_n = 0; gq.delete();
        n_ifv = 0; n_dv = 0; last_wi = 0; last_wd = 0;
    endtask

    task automatic model();
        bit wi, wd;
        chk("if_rvalid", if_rvalid, exp_ifv);
        chk("if_rdata", if_rdata, exp_ifd);
        chk("d_rvalid", d_rvalid, exp_dv);
        chk("d_rdata", d_rdata, exp_dd);
        if (exp_ifv) begin n_ifv++; last_ifv_cyc = cyc; end
        if (exp_dv)  begin n_dv++;  last_dv_cyc  = cyc; end
        exp_ifv = 0; exp_dv = 0;
        wi = 0; wd = 0;
        if (!busy && !cool) begin
            if (d_req && !(if_req && starve == SM)) wd = 1;
            else if (if_req) wi = 1;
        end
        chk("if_gnt", if_gnt, wi);
        chk("d_gnt", d_gnt, wd);
        cool = 0;
        if (busy) begin
            chk("m_req", m_req, 1);
            chk("m_addr", m_addr, t_addr);
            chk("m_we", m_we, t_we);
            chk("m_type", m_type, t_type);
            if (t_we) chk("m_wdata", m_wdata, t_wdata);
            if (first_m) begin mreq_first = cyc; first_m = 0; end
            mreq_last = cyc;
            if (t_if && if_flush) flushed = 1;
            if (m_ack) begin
                busy = 0; cool = 1;
                if (t_if) begin
                    if (!flushed) begin exp_ifv = 1; exp_ifd = mem_rd(t_addr); end
                end else begin
                    exp_dv = 1;
                    if (t_we) mem[t_addr] = t_wdata;
                    else exp_dd = mem_rd(t_addr);
                end
            end
        end else begin
            chk("m_req idle", m_req, 0);
        end
        if (wi || wd) begin
            busy = 1; t_if = wi; flushed = wi && if_flush; first_m = 1; gnt_cyc = cyc;
            t_addr  = wi ? if_addr : d_addr;
            t_we    = wd && d_we;
            t_type  = wi ? 3'b010 : d_type;
            t_wdata = d_wdata;
            gq.push_back(wi ? "I" : "D");
            if (wi) if_gnt_cyc = cyc;
            if (rand_dly) ack_dly = $urandom_range(0, 3);
        end
        if (!if_req || wi) starve = 0;
        else if (wd && starve < SM) starve++;
        last_wi = wi; last_wd = wd;
    endtask

    // One clock: memory responds and the model checks at the falling edge;
    // requesters update just after the rising edge.
    task automatic step();
        @(negedge clk);
        if (m_req) begin
            m_ack = (wait_n >= ack_dly);
            m_rdata = m_ack ? mem_rd(m_addr) : $urandom;
            wait_n++;
        end else begin
            m_ack = stray; m_rdata = $urandom; wait_n = 0;
        end
        if (!reset) model();
        @(posedge clk); #1; cyc++;
        if (auto_rq) begin
            if (if_req && last_wi) if_req = 0;
            else if (if_req && $urandom_range(0, 15) == 0) if_req = 0;
            else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1; if_addr = 32'($urandom_range(0, 63)) << 2;
            end
            if (d_req && last_wd) d_req = 0;
            else if (d_req && $urandom_range(0, 15) == 0) d_req = 0;
            else if (!d_req && $urandom_range(0, 1) == 0) begin
                d_req = 1; d_we = $urandom_range(0, 1); d_type = 3'($urandom_range(0, 7));
                d_addr = 32'($urandom_range(0, 63)) << 2; d_wdata = $urandom;
            end
            if_flush = ($urandom_range(0, 7) == 0);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " if_gnt"}, if_gnt, 0);    chk({nm, " d_gnt"}, d_gnt, 0);
        chk({nm, " if_rvalid"}, if_rvalid, 0); chk({nm, " d_rvalid"}, d_rvalid, 0);
        chk({nm, " if_rdata"}, if_rdata, 0); chk({nm, " d_rdata"}, d_rdata, 0);
        chk({nm, " m_req"}, m_req, 0);      chk({nm, " m_we"}, m_we, 0);
        chk({nm, " m_type"}, m_type, 0);    chk({nm, " m_addr"}, m_addr, 0);
        chk({nm, " m_wdata"}, m_wdata, 0);
    endtask

    task automatic do_reset();
        reset = 1; if_req = 0; d_req = 0; if_flush = 0; d_we = 0; d_type = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0; auto_rq = 0; rand_dly = 0; stray = 0; ack_dly = 0;
        repeat (2) step();
        chk_all_zero("reset");
        model_clear();
        reset = 0;
    endtask

    typedef struct {
        bit ir, dr, dwe; logic [2:0] dt;
        bit e_ig, e_dg, e_we; logic [2:0] e_ty;
    } vec_t;
    vec_t vecs[6];

    initial begin
        string exp_seq;
        int dv0;
        m_ack = 0; m_rdata = 0; reset = 1;

        vecs[0] = '{0, 0, 0, 3'd0, 0, 0, 0, 3'd0};
        vecs[1] = '{1, 0, 0, 3'd0, 1, 0, 0, 3'd2};
        vecs[2] = '{0, 1, 0, 3'd0, 0, 1, 0, 3'd0};
        vecs[3] = '{0, 1, 1, 3'd2, 0, 1, 1, 3'd2};
        vecs[4] = '{1, 1, 0, 3'd5, 0, 1, 0, 3'd5};
        vecs[5] = '{1, 1, 1, 3'd1, 0, 1, 1, 3'd1};

        // Table vectors: arbitration out of a fresh reset.
        foreach (vecs[i]) begin
            do_reset();
            if_req = vecs[i].ir; if_addr = 32'h80 + 32'(i) * 4;
            d_req = vecs[i].dr; d_we = vecs[i].dwe; d_type = vecs[i].dt;
            d_addr = 32'h1000 + 32'(i) * 4; d_wdata = 32'hA0 + 32'(i);
            #3;
            chk("vec if_gnt", if_gnt, vecs[i].e_ig);
            chk("vec d_gnt", d_gnt, vecs[i].e_dg);
            step();
            if_req = 0; d_req = 0;
            #3;
            chk("vec m_req", m_req, vecs[i].e_ig | vecs[i].e_dg);
            chk("vec m_we", m_we, vecs[i].e_we);
            chk("vec m_type", m_type, vecs[i].e_ty);
            repeat (4) step();
        end

        // Lone fetch, 0x100, ack in first request cycle.
        do_reset();
        if_req = 1; if_addr = 32'h100;
        step(); if_req = 0;
        repeat (4) step();
        chk("lat m_req first", mreq_first, gnt_cyc + 1);
        chk("lat m_req last", mreq_last, gnt_cyc + 1);
        chk("lat if_rvalid cyc", last_ifv_cyc, gnt_cyc + 2);
        chk("lat if_rvalid count", n_ifv, 1);
        chk("lat if_rdata", if_rdata, mem_rd(32'h100));

        // Fetch and load together: data first, fetch after d_rvalid.
        do_reset();
        if_req = 1; if_addr = 32'h104;
        d_req = 1; d_we = 0; d_type = 3'b100; d_addr = 32'h2000;
        step(); d_req = 0;
        repeat (8) begin step(); if (last_wi) if_req = 0; end
        chk("both order0", gq[0], "D");
        chk("both order1", gq[1], "I");
        chk("both fetch after d_rvalid", if_gnt_cyc > last_dv_cyc, 1);
        chk("both d_rdata", d_rdata, mem_rd(32'h2000));

        // Starvation bound.
        do_reset();
        if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_type = 3'b010; d_addr = 32'h3000;
        repeat (20) step();
        exp_seq = "DDDDID";
        chk("starve grant count", gq.size() >= 6, 1);
        for (int k = 0; k < 6; k++)
            if (k < gq.size()) chk($sformatf("starve grant %0d", k), gq[k], exp_seq[k]);
        if_req = 0; d_req = 0;
        repeat (6) step();

        // Load then slow store: m_* stable, one d_rvalid, d_rdata kept.
        do_reset();
        d_req = 1; d_we = 0; d_type = 3'b010; d_addr = 32'h40;
        step(); d_req = 0; repeat (4) step();
        dv0 = n_dv; ack_dly = 5;
        d_req = 1; d_we = 1; d_addr = 32'h44; d_wdata = 32'hDEADBEEF;
        step(); d_req = 0; repeat (10) step();
        chk("store m_req cycles", mreq_last - mreq_first + 1, 6);
        chk("store d_rvalid count", n_dv - dv0, 1);
        chk("store d_rdata kept", d_rdata, mem_rd(32'h40));
        ack_dly = 0;
        d_req = 1; d_we = 0; d_addr = 32'h44;
        step(); d_req = 0; repeat (4) step();
        chk("store readback", d_rdata, 32'hDEADBEEF);

        // Flush during a fetch, idle flush, then a normal fetch; stray acks.
        do_reset();
        ack_dly = 3;
        if_req = 1; if_addr = 32'h300;
        step(); if_req = 0; step();
        if_flush = 1; step(); if_flush = 0;
        repeat (6) step();
        chk("flush no rvalid", n_ifv, 0);
        chk("flush if_rdata held", if_rdata, 0);
        stray = 1; if_flush = 1; repeat (3) step(); stray = 0; if_flush = 0;
        ack_dly = 0;
        if_req = 1; if_addr = 32'h304;
        step(); if_req = 0; repeat (4) step();
        chk("after flush rvalid", n_ifv, 1);
        chk("after flush if_rdata", if_rdata, mem_rd(32'h304));

        // Randomized traffic against the model.
        do_reset();
        auto_rq = 1; rand_dly = 1;
        repeat (3000) begin stray = ($urandom_range(0, 9) == 0); step(); end
        auto_rq = 0; stray = 0; if_req = 0; d_req = 0; if_flush = 0;
        repeat (8) step();
        chk("random activity", gq.size() > 200, 1);

        // Reset in the middle of a load.
        do_reset();
        ack_dly = 10;
        d_req = 1; d_we = 0; d_type = 3'b000; d_addr = 32'h500;
        step(); d_req = 0; repeat (2) step();
        chk("midreset busy", m_req, 1);
        #2 reset = 1;
        #1;
        chk("midreset m_req async", m_req, 0);
        repeat (3) begin
            step();
            chk("midreset no d_rvalid", d_rvalid, 0);
        end
        model_clear(); ack_dly = 0;
        reset = 0;
        repeat (2) step();
        chk_all_zero("post reset");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
